// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit CPU:
// control-word fields, phase encoding and the decode-address layout.
package cpu4_pkg;

    // Control word returned by the decode ROM
    localparam int unsigned CW_W        = 13;
    localparam int unsigned INC_BIT     = 12;  // incPC
    localparam int unsigned LDPC_BIT    = 11;  // loadPC
    localparam int unsigned WRMEM_BIT   = 10;  // write data memory
    localparam int unsigned LDFL_BIT    = 9;   // loadFlags
    localparam int unsigned LDACC_BIT   = 8;   // load accumulator
    localparam int unsigned ALU_OP_HI   = 7;   // ALU opcode field
    localparam int unsigned ALU_OP_LO   = 5;
    localparam int unsigned SRC_SEL_HI  = 4;   // ALU B-operand select
    localparam int unsigned SRC_SEL_LO  = 3;
    localparam int unsigned OUT_EN_BIT  = 2;   // drive output port
    localparam int unsigned IN_EN_BIT   = 1;   // sample input port
    localparam int unsigned HALT_BIT    = 0;   // halt

    // Fetch/execute phase flip-flop
    typedef enum logic {
        PHASE_FETCH = 1'b0,
        PHASE_EXEC  = 1'b1
    } phase_t;

    // Decode ROM address layout {instr[3:0], C, Z, phase}
    localparam int unsigned DA_W        = 7;
    localparam int unsigned DA_PHASE    = 0;
    localparam int unsigned DA_ZERO     = 1;
    localparam int unsigned DA_CARRY    = 2;
    localparam int unsigned DA_INSTR_LO = 3;
    localparam int unsigned DA_INSTR_HI = 6;

    function automatic logic [DA_W-1:0] make_dec_addr(
        input logic [3:0] instr,
        input logic       carry,
        input logic       zero,
        input logic       phase
    );
        logic [DA_W-1:0] a;
        a = '0;
        a[DA_INSTR_HI:DA_INSTR_LO] = instr;
        a[DA_CARRY]                = carry;
        a[DA_ZERO]                 = zero;
        a[DA_PHASE]                = phase;
        return a;
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_counter.sv
// Program counter: load beats increment, increment wraps modulo 2^W.
module pc_counter #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] pc
);

    // PC register with load/increment/hold priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= '0;
        end else if (en) begin
            if (load) begin
                pc <= load_val;
            end else if (inc) begin
                pc <= pc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: PC, instruction register, phase FSM and C/Z flags.
// Builds the decode-ROM address and acts on the returned control word.
module fetch_sequencer #(
    parameter int unsigned PC_W     = 12,
    parameter int unsigned INC_BIT  = cpu4_pkg::INC_BIT,
    parameter int unsigned LDPC_BIT = cpu4_pkg::LDPC_BIT,
    parameter int unsigned LDFL_BIT = cpu4_pkg::LDFL_BIT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic [7:0]      prog_byte,
    input  logic [12:0]     ctrl_word,
    input  logic            alu_carry,
    input  logic            alu_zero,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      instr,
    output logic [3:0]      oprnd,
    output logic            phase,
    output logic            carry,
    output logic            zero,
    output logic [6:0]      dec_addr,
    output logic            instr_done
);
    import cpu4_pkg::*;

    phase_t     state, state_nx;
    logic [3:0] instr_nx, oprnd_nx;
    logic       carry_nx, zero_nx, done_nx, done_q;
    logic       pc_load;
    logic [11:0] jump_target;
    logic       unused_ctrl;

    // Only incPC, loadPC and loadFlags matter here
    assign unused_ctrl = ^ctrl_word;

    // Jump target is operand nibble plus the byte following the opcode
    assign jump_target = {oprnd, prog_byte};
    assign pc_load     = (state == PHASE_EXEC) && ctrl_word[LDPC_BIT];

    pc_counter #(.W(PC_W)) u_pc (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .load     (pc_load),
        .inc      (ctrl_word[INC_BIT]),
        .load_val (PC_W'(jump_target)),
        .pc       (pc)
    );

    // Phase, instruction register, flags and completion pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= PHASE_FETCH;
            instr  <= '0;
            oprnd  <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            done_q <= 1'b0;
        end else if (en) begin
            state  <= state_nx;
            instr  <= instr_nx;
            oprnd  <= oprnd_nx;
            carry  <= carry_nx;
            zero   <= zero_nx;
            done_q <= done_nx;
        end else begin
            done_q <= 1'b0;
        end
    end

    // Next-state logic for the fetch/execute phase FSM
    always_comb begin
        state_nx = state;
        instr_nx = instr;
        oprnd_nx = oprnd;
        carry_nx = carry;
        zero_nx  = zero;
        done_nx  = 1'b0;
        case (state)
            PHASE_FETCH: begin
                {instr_nx, oprnd_nx} = prog_byte;
                state_nx             = PHASE_EXEC;
            end
            PHASE_EXEC: begin
                if (ctrl_word[LDFL_BIT]) begin
                    carry_nx = alu_carry;
                    zero_nx  = alu_zero;
                end
                state_nx = PHASE_FETCH;
                done_nx  = 1'b1;
            end
            default: state_nx = PHASE_FETCH;
        endcase
    end

    // Pulse is suppressed immediately when the enable drops
    assign instr_done = done_q & en;
    assign phase      = state;
    assign dec_addr   = make_dec_addr(instr, carry, zero, phase);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

    localparam logic [12:0] INC  = 13'h1000;
    localparam logic [12:0] LDPC = 13'h0800;
    localparam logic [12:0] LDFL = 13'h0200;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic [7:0]  prog_byte;
    logic [12:0] ctrl_word;
    logic        alu_carry;
    logic        alu_zero;
    logic [11:0] pc;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic        phase;
    logic        carry;
    logic        zero;
    logic [6:0]  dec_addr;
    logic        instr_done;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(
        .PC_W     (12),
        .INC_BIT  (12),
        .LDPC_BIT (11),
        .LDFL_BIT (9)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .prog_byte  (prog_byte),
        .ctrl_word  (ctrl_word),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .pc         (pc),
        .instr      (instr),
        .oprnd      (oprnd),
        .phase      (phase),
        .carry      (carry),
        .zero       (zero),
        .dec_addr   (dec_addr),
        .instr_done (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        en        = 1'b1;
        prog_byte = 8'h00;
        ctrl_word = '0;
        alu_carry = 1'b0;
        alu_zero  = 1'b0;

        // Reset values
        #12;
        chk("rst_pc", 32'(pc), 32'h000);
        chk("rst_phase", 32'(phase), 32'h0);
        chk("rst_dec", 32'(dec_addr), 32'h00);
        chk("rst_done", 32'(instr_done), 32'h0);
        chk("rst_flags", 32'({carry, zero}), 32'h0);
        reset_n = 1'b1;

        // Straight-line instruction 0x2A with incPC in both phases
        prog_byte = 8'h2A; ctrl_word = INC;
        step();
        chk("f1_instr", 32'(instr), 32'h2);
        chk("f1_oprnd", 32'(oprnd), 32'hA);
        chk("f1_pc", 32'(pc), 32'h001);
        chk("f1_phase", 32'(phase), 32'h1);
        chk("f1_done", 32'(instr_done), 32'h0);
        step();
        chk("e1_pc", 32'(pc), 32'h002);
        chk("e1_phase", 32'(phase), 32'h0);
        chk("e1_done", 32'(instr_done), 32'h1);
        chk("e1_dec", 32'(dec_addr), 32'h10);

        // Jump: load and increment both set, load wins
        prog_byte = 8'h93; ctrl_word = INC;
        step();
        chk("f2_pc", 32'(pc), 32'h003);
        chk("f2_oprnd", 32'(oprnd), 32'h3);
        chk("f2_done", 32'(instr_done), 32'h0);
        prog_byte = 8'hC5; ctrl_word = INC | LDPC;
        step();
        chk("jmp_pc", 32'(pc), 32'h3C5);
        chk("jmp_done", 32'(instr_done), 32'h1);

        // Flags loaded in execute
        prog_byte = 8'h40; ctrl_word = INC;
        step();
        chk("f3_pc", 32'(pc), 32'h3C6);
        prog_byte = 8'h00; ctrl_word = INC | LDFL; alu_carry = 1'b1; alu_zero = 1'b0;
        step();
        chk("fl_flags", 32'({carry, zero}), 32'h2);
        chk("fl_pc", 32'(pc), 32'h3C7);
        chk("fl_dec", 32'(dec_addr), 32'h24);

        // Fetch ignores loadFlags; execute without loadFlags holds them
        prog_byte = 8'h51; ctrl_word = INC | LDFL; alu_carry = 1'b0; alu_zero = 1'b1;
        step();
        chk("f4_flags", 32'({carry, zero}), 32'h2);
        chk("f4_dec", 32'(dec_addr), 32'h2D);
        prog_byte = 8'h00; ctrl_word = INC;
        step();
        chk("e4_flags", 32'({carry, zero}), 32'h2);
        chk("e4_pc", 32'(pc), 32'h3C9);

        // Jump to 0xFFF, then wrap on increment
        prog_byte = 8'hEF; ctrl_word = INC;
        step();
        chk("f5_pc", 32'(pc), 32'h3CA);
        prog_byte = 8'hFF; ctrl_word = LDPC;
        step();
        chk("e5_pc", 32'(pc), 32'hFFF);
        prog_byte = 8'h10; ctrl_word = INC;
        step();
        chk("wrap_pc", 32'(pc), 32'h000);
        chk("wrap_instr", 32'(instr), 32'h1);
        ctrl_word = '0;
        step();
        chk("hold_pc", 32'(pc), 32'h000);
        chk("e6_dec", 32'(dec_addr), 32'h0C);
        chk("e6_done", 32'(instr_done), 32'h1);

        // Enable low for 5 cycles mid-execute
        prog_byte = 8'h70; ctrl_word = INC;
        step();
        chk("f7_pc", 32'(pc), 32'h001);
        en = 1'b0; prog_byte = 8'hAB; ctrl_word = INC | LDPC | LDFL;
        alu_carry = 1'b0; alu_zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("en0_pc", 32'(pc), 32'h001);
            chk("en0_phase", 32'(phase), 32'h1);
            chk("en0_ir", 32'({instr, oprnd}), 32'h70);
            chk("en0_flags", 32'({carry, zero}), 32'h2);
            chk("en0_done", 32'(instr_done), 32'h0);
        end
        en = 1'b1; ctrl_word = INC | LDFL;
        step();
        chk("en1_pc", 32'(pc), 32'h002);
        chk("en1_phase", 32'(phase), 32'h0);
        chk("en1_flags", 32'({carry, zero}), 32'h1);
        chk("en1_done", 32'(instr_done), 32'h1);

        // Build pc=0x123 then reset mid-execute without a clock edge
        prog_byte = 8'h81; ctrl_word = '0;
        step();
        prog_byte = 8'h23; ctrl_word = LDPC;
        step();
        chk("j2_pc", 32'(pc), 32'h123);
        prog_byte = 8'h00; ctrl_word = '0;
        step();
        chk("pre_rst_pc", 32'(pc), 32'h123);
        chk("pre_rst_phase", 32'(phase), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_pc", 32'(pc), 32'h000);
        chk("arst_phase", 32'(phase), 32'h0);
        chk("arst_dec", 32'(dec_addr), 32'h00);
        chk("arst_flags", 32'({carry, zero}), 32'h0);
        #3;
        reset_n = 1'b1;

        // First fetch after release reads address 0
        prog_byte = 8'h2A; ctrl_word = INC;
        step();
        chk("post_pc", 32'(pc), 32'h001);
        chk("post_instr", 32'(instr), 32'h2);
        chk("post_phase", 32'(phase), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
